icache: RTL and testbench

//  Direct-mapped, one-word-per-line instruction cache; responder side of the fetch-unit read port.

---
 rtl/icache.sv | 118 +++++++++++
 tb/tb_icache.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache with one word per line. Lookup is combinational and a miss refills one word.
// Defining ICACHE_FLUSH_EN lets flush invalidate every line and abort a refill in progress.
module icache #(
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    output logic        hit,
    output logic [31:0] hit_inst,
    output logic        mem_rd_en,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    input  logic        flush
);

    localparam int TAG_BITS = 32 - INDEX_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                state;
    state_t                state_next;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  fill;
    logic                  clear;
    logic                  flush_req;
    logic                  mem_rd_en_next;
    logic [31:0]           mem_rd_addr_next;
    logic [3:0]            unused_bits;

`ifdef ICACHE_FLUSH_EN
    assign flush_req = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_req    = 1'b0;
`endif

    assign unused_bits = {rd_addr[1:0], mem_rd_addr[1:0]};

    assign idx      = rd_addr[INDEX_BITS+1:2];
    assign rd_tag   = rd_addr[31:INDEX_BITS+2];
    // The registered refill address doubles as the latched miss address.
    assign fill_idx = mem_rd_addr[INDEX_BITS+1:2];
    assign fill_tag = mem_rd_addr[31:INDEX_BITS+2];

    assign hit      = rd_en && valid[idx] && (tag_mem[idx] == rd_tag);
    assign hit_inst = data_mem[idx];

    always_comb begin
        state_next       = state;
        mem_rd_en_next   = mem_rd_en;
        mem_rd_addr_next = mem_rd_addr;
        fill             = 1'b0;
        clear            = 1'b0;
        case (state)
            IDLE: begin
                if (rd_en && !hit) begin
                    mem_rd_en_next   = 1'b1;
                    mem_rd_addr_next = {rd_addr[31:2], 2'b00};
                    state_next       = REFILL;
                end
            end
            REFILL: begin
                if (mem_done) begin
                    fill           = 1'b1;
                    mem_rd_en_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Flush wins over a completing refill: nothing is written that cycle.
        if (flush_req) begin
            clear          = 1'b1;
            fill           = 1'b0;
            mem_rd_en_next = 1'b0;
            state_next     = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            valid       <= '0;
        end else if (rdy) begin
            state       <= state_next;
            mem_rd_en   <= mem_rd_en_next;
            mem_rd_addr <= mem_rd_addr_next;
            if (clear) begin
                valid <= '0;
            end else if (fill) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_data;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: a reference cache model predicts hit/data for each lookup; predictions are queued and compared at the negedge.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        hit;
    logic [31:0] hit_inst;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        flush;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        h;
        logic [31:0] inst;
    } exp_t;
    exp_t sb_q[$];

    bit          m_vld  [256];
    logic [31:0] m_addr [256];
    logic [31:0] m_data [256];

    icache dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rd_en(rd_en), .rd_addr(rd_addr),
        .hit(hit), .hit_inst(hit_inst), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_done(mem_done), .mem_data(mem_data), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tg, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tg, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_vld[i] = 1'b0;
    endtask

    task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
        logic [7:0] i;
        i = a[9:2];
        m_vld[i]  = 1'b1;
        m_addr[i] = {a[31:2], 2'b00};
        m_data[i] = d;
    endtask

    task automatic push_expect(input logic [31:0] a);
        exp_t       e;
        logic [7:0] i;
        logic [31:0] ma;
        i      = a[9:2];
        ma     = m_addr[i];
        e.h    = m_vld[i] && (ma[31:10] == a[31:10]);
        e.inst = m_data[i];
        sb_q.push_back(e);
    endtask

    // Predict from the model for the current rd_addr, then compare at the negedge.
    task automatic sample(input string tg);
        exp_t e;
        push_expect(rd_addr);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check({tg, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tg, "_hit"}, {31'd0, hit}, {31'd0, e.h});
            if (e.h) check({tg, "_inst"}, hit_inst, e.inst);
        end
    endtask

    task automatic lookup_chk(input logic [31:0] a, input string tg);
        step();
        rd_en   = 1'b1;
        rd_addr = a;
        sample(tg);
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input int wait_cyc, input string tg);
        lookup_chk(a, {tg, "_miss"});
        step();
        @(negedge clk);
        check({tg, "_req_en"}, {31'd0, mem_rd_en}, 32'd1);
        check({tg, "_req_addr"}, mem_rd_addr, {a[31:2], 2'b00});
        for (int w = 0; w < wait_cyc; w++) begin
            step();
            @(negedge clk);
            check({tg, "_hold_en"}, {31'd0, mem_rd_en}, 32'd1);
            check({tg, "_hold_addr"}, mem_rd_addr, {a[31:2], 2'b00});
        end
        step();
        mem_done = 1'b1;
        mem_data = d;
        @(negedge clk);
        check({tg, "_done_cycle_hit"}, {31'd0, hit}, 32'd0);
        step();
        mem_done = 1'b0;
        mem_data = 32'hx;
        model_fill(a, d);
        sample({tg, "_after_fill"});
        check({tg, "_req_drop"}, {31'd0, mem_rd_en}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        rdy      = 1'b1;
        rd_en    = 1'b1;
        rd_addr  = 32'h0;
        mem_done = 1'b0;
        mem_data = 32'h0;
        flush    = 1'b0;
        model_clear();

        // Reset state
        @(negedge clk);
        check("rst_hit", {31'd0, hit}, 32'd0);
        check("rst_mem_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("rst_mem_rd_addr", mem_rd_addr, 32'd0);
        step();
        rst   = 1'b0;
        rd_en = 1'b0;

        // Cold misses, including a stored zero word and a delayed memory
        do_miss(32'h0000_0000, 32'h0000_0013, 0, "cold0");
        do_miss(32'h0000_0104, 32'h0050_0093, 2, "cold104");
        check("cold104_const", hit_inst, 32'h0050_0093);
        do_miss(32'h0000_0008, 32'h0000_0000, 1, "zero_word");

        // Conflict at the same index
        do_miss(32'h0000_0004, 32'h1111_1111, 0, "conf004");
        do_miss(32'h0000_0404, 32'h2222_2222, 0, "conf404");
        lookup_chk(32'h0000_0404, "conf404_again");
        do_miss(32'h0000_0004, 32'h3333_3333, 0, "conf004_refetch");

        // Resident hit during a refill, then a rollback address that must not start a second refill
        lookup_chk(32'h0000_0200, "r200_miss");
        step();
        rd_addr = 32'h0000_0104;
        sample("r104_during_refill");
        check("r104_const", hit_inst, 32'h0050_0093);
        check("r200_req_en", {31'd0, mem_rd_en}, 32'd1);
        step();
        rd_addr = 32'h0000_0300;
        sample("r300_rollback");
        check("r300_no_requeue", mem_rd_addr, 32'h0000_0200);
        step();
        mem_done = 1'b1;
        mem_data = 32'h4444_4444;
        @(negedge clk);
        check("r200_done_addr", mem_rd_addr, 32'h0000_0200);
        step();
        mem_done = 1'b0;
        model_fill(32'h0000_0200, 32'h4444_4444);
        rd_addr = 32'h0000_0200;
        sample("r200_filled");
        check("r200_req_drop", {31'd0, mem_rd_en}, 32'd0);
        do_miss(32'h0000_0300, 32'h5555_5555, 0, "r300_own_refill");

        // Global ready low freezes the FSM while lookups stay live
        step();
        rdy     = 1'b0;
        rd_addr = 32'h0000_0500;
        sample("rdy0_miss");
        step();
        @(negedge clk);
        check("rdy0_no_req", {31'd0, mem_rd_en}, 32'd0);
        lookup_chk(32'h0000_0104, "rdy0_hit");
        step();
        rdy   = 1'b1;
        rd_en = 1'b0;

        // Stale mem_done in IDLE is ignored
        step();
        mem_done = 1'b1;
        mem_data = 32'hDEAD_BEEF;
        step();
        mem_done = 1'b0;
        lookup_chk(32'h0000_0200, "stale_done");
        check("stale_no_req", {31'd0, mem_rd_en}, 32'd0);

        // Reset during a refill discards it
        lookup_chk(32'h0000_0700, "r700_miss");
        step();
        rd_en = 1'b0;
        @(negedge clk);
        check("r700_req_en", {31'd0, mem_rd_en}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        mem_done = 1'b1;
        mem_data = 32'h7777_0000;
        model_clear();
        @(negedge clk);
        check("rst_mid_req_en", {31'd0, mem_rd_en}, 32'd0);
        step();
        mem_done = 1'b0;
        @(negedge clk);
        check("rst_mid_req_en2", {31'd0, mem_rd_en}, 32'd0);
        do_miss(32'h0000_0104, 32'h0050_0093, 0, "post_rst104");
        do_miss(32'h0000_0700, 32'h7777_7777, 0, "post_rst700");

        // Flush behaviour depends on the build option
        do_miss(32'h0000_0000, 32'hA0A0_A0A0, 0, "fl0");
        do_miss(32'h0000_0004, 32'hA4A4_A4A4, 0, "fl4");
        step();
        rd_en = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
`ifdef ICACHE_FLUSH_EN
        model_clear();
`endif
        lookup_chk(32'h0000_0000, "flush_0");
        lookup_chk(32'h0000_0004, "flush_4");
        step();
        rd_en = 1'b0;
        @(negedge clk);
`ifdef ICACHE_FLUSH_EN
        check("flush_refill_started", {31'd0, mem_rd_en}, 32'd1);
`else
        check("noflush_idle", {31'd0, mem_rd_en}, 32'd0);
`endif
        step();
        flush = 1'b1;
        step();
        flush    = 1'b0;
        mem_done = 1'b1;
        mem_data = 32'hBBBB_BBBB;
`ifdef ICACHE_FLUSH_EN
        model_clear();
`endif
        @(negedge clk);
        check("flush_abort_req", {31'd0, mem_rd_en}, 32'd0);
        step();
        mem_done = 1'b0;
        lookup_chk(32'h0000_0000, "flush_late_done");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
